arith_result_serializer: RTL and testbench

- Downstream stage of the 16-bit arithmetic unit: captures each registered 2*WIDTH-bit result qualified by Arith_Flag.
- Buffers results in a small FIFO and streams each one out as OUT_W-bit beats, MSB beat first, over a valid/ready interface.
- Feeds the byte-wide output or UART transmit path; absorbs back-pressure so the ALU never stalls.

---
 rtl/arith_result_serializer.sv | 100 ++++++++++
 tb/tb_arith_result_serializer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/arith_result_serializer.sv
// Captures flagged arithmetic results into a small FIFO and streams each one out
// as OUT_W-bit beats, most significant beat first, over a valid/ready interface.
module arith_result_serializer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int OUT_W = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [2*WIDTH-1:0] Arith_OUT,
  input  logic               Arith_Flag,
  output logic [OUT_W-1:0]   Tx_Data,
  output logic               Tx_Valid,
  input  logic               Tx_Ready,
  output logic               Tx_Last,
  output logic               Fifo_Full,
  output logic [7:0]         Drop_Count,
  output logic               Busy
);

  localparam int RW = 2 * WIDTH;
  localparam int NB = RW / OUT_W;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  // Handshake: a beat moves on a CLK edge where Tx_Valid and Tx_Ready are both
  // high; while Tx_Valid is high and Tx_Ready low, Tx_Data/Tx_Last are frozen.
  state_t          state, state_next;
  logic [RW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_next;
  logic [BW-1:0]   beat_cnt, beat_next;
  logic [RW-1:0]   shift_reg, shift_next;
  logic            xfer, last_xfer, pop, push;

  always_comb begin
    xfer       = (state == SEND) && Tx_Ready;
    last_xfer  = xfer && (beat_cnt == BW'(NB - 1));
    // Pop decision uses the pre-edge count, so an empty FIFO never bypasses.
    pop        = (count != '0) && ((state == IDLE) || last_xfer);
    push       = Arith_Flag && ((count < CW'(DEPTH)) || pop);
    count_next = count + CW'(push) - CW'(pop);

    state_next = state;
    if (state == IDLE) begin
      if (pop) state_next = SEND;
    end else if (last_xfer && !pop) begin
      state_next = IDLE;
    end

    beat_next  = beat_cnt;
    shift_next = shift_reg;
    if (pop) begin
      beat_next  = '0;
      shift_next = mem[rd_ptr];
    end else if (xfer) begin
      beat_next  = beat_cnt + BW'(1);
      shift_next = shift_reg << OUT_W;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= Arith_OUT;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      beat_cnt   <= '0;
      shift_reg  <= '0;
      Tx_Valid   <= 1'b0;
      Tx_Last    <= 1'b0;
      Fifo_Full  <= 1'b0;
      Drop_Count <= '0;
      Busy       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_next;
      state     <= state_next;
      beat_cnt  <= beat_next;
      shift_reg <= shift_next;
      Tx_Valid  <= (state_next == SEND);
      Tx_Last   <= (state_next == SEND) && (beat_next == BW'(NB - 1));
      Fifo_Full <= (count_next == CW'(DEPTH));
      Busy      <= (count_next != '0) || (state_next == SEND);
      if (Arith_Flag && !push && (Drop_Count != 8'hFF))
        Drop_Count <= Drop_Count + 8'd1;
    end
  end

  assign Tx_Data = shift_reg[RW-1 -: OUT_W];

endmodule

// File: tb/tb_arith_result_serializer.sv
// Directed bench: a driver pushes expected beats into a queue, a negedge monitor
// pops and compares every transferred beat and checks stall stability.
module tb_arith_result_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] arith_out;
  logic        arith_flag;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic        fifo_full;
  logic [7:0]  drop_count;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int xfer_cnt = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  arith_result_serializer #(.WIDTH(16), .DEPTH(4), .OUT_W(8)) dut (
    .CLK(clk), .RST(rst), .Arith_OUT(arith_out), .Arith_Flag(arith_flag),
    .Tx_Data(tx_data), .Tx_Valid(tx_valid), .Tx_Ready(tx_ready),
    .Tx_Last(tx_last), .Fifo_Full(fifo_full), .Drop_Count(drop_count),
    .Busy(busy)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One flagged cycle; when accepted, its four beats are queued MSB first.
  task automatic push(input logic [31:0] val, input bit accept);
    arith_out  = val;
    arith_flag = 1'b1;
    if (accept)
      for (int i = 0; i < 4; i++)
        exp_q.push_back({(i == 3), val[31 - 8*i -: 8]});
    tick();
    arith_flag = 1'b0;
  endtask

  // Monitor
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {31'd0, tx_valid}, 32'd1);
        chk("stall_data", {24'd0, tx_data}, {24'd0, prev_data});
        chk("stall_last", {31'd0, tx_last}, {31'd0, prev_last});
      end
      if (tx_valid && tx_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {23'd0, tx_last, tx_data}, 32'h1ff);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("beat_data", {24'd0, tx_data}, {24'd0, e[7:0]});
          chk("beat_last", {31'd0, tx_last}, {31'd0, e[8]});
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_last  = tx_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int xs;
    logic [3:0] pat;
    rst = 1'b1; arith_out = '0; arith_flag = 1'b0; tx_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_data",  {24'd0, tx_data}, 32'd0);
    chk("rst_last",  {31'd0, tx_last}, 32'd0);
    chk("rst_full",  {31'd0, fifo_full}, 32'd0);
    chk("rst_drop",  {24'd0, drop_count}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);

    // Single result, first beat valid one edge after capture
    tx_ready = 1'b1;
    push(32'h1234_ABCD, 1'b1);
    chk("lat_valid_n", {31'd0, tx_valid}, 32'd0);
    chk("lat_busy_n",  {31'd0, busy}, 32'd1);
    tick();
    chk("lat_valid_n1", {31'd0, tx_valid}, 32'd1);
    chk("lat_data_n1",  {24'd0, tx_data}, 32'h12);
    repeat (4) tick();
    chk("single_idle_valid", {31'd0, tx_valid}, 32'd0);
    chk("single_idle_busy",  {31'd0, busy}, 32'd0);
    chk("single_q_empty", exp_q.size(), 32'd0);

    // Back-pressure with ready pattern 1,0,0,1
    tx_ready = 1'b0;
    xs = xfer_cnt;
    push(32'h1234_ABCD, 1'b1);
    pat = 4'b1001;
    for (int i = 0; i < 24; i++) begin
      tx_ready = pat[i % 4];
      tick();
    end
    chk("bp_xfers", xfer_cnt - xs, 32'd4);
    chk("bp_busy", {31'd0, busy}, 32'd0);
    chk("bp_q_empty", exp_q.size(), 32'd0);

    // Back-to-back results stream with no bubble
    tx_ready = 1'b1;
    xs = xfer_cnt;
    push(32'd1, 1'b1);
    push(32'd2, 1'b1);
    push(32'd3, 1'b1);
    repeat (11) tick();
    chk("b2b_xfers_contig", xfer_cnt - xs, 32'd12);
    chk("b2b_idle_valid", {31'd0, tx_valid}, 32'd0);
    chk("b2b_q_empty", exp_q.size(), 32'd0);

    // Overflow: one result in the shift register, four in the FIFO, one dropped
    tx_ready = 1'b0;
    push(32'd1, 1'b1);
    push(32'd2, 1'b1);
    push(32'd3, 1'b1);
    push(32'd4, 1'b1);
    chk("ovf_full_early", {31'd0, fifo_full}, 32'd0);
    push(32'd5, 1'b1);
    chk("ovf_full", {31'd0, fifo_full}, 32'd1);
    chk("ovf_drop0", {24'd0, drop_count}, 32'd0);
    push(32'd6, 1'b0);
    chk("ovf_drop1", {24'd0, drop_count}, 32'd1);
    chk("ovf_stalled_data", {24'd0, tx_data}, 32'h00);

    // Push at full on the edge the last beat of the active result transfers
    tx_ready = 1'b1;
    repeat (3) tick();
    push(32'hDEAD_BEEF, 1'b1);
    chk("popfull_drop", {24'd0, drop_count}, 32'd1);
    chk("popfull_full", {31'd0, fifo_full}, 32'd1);
    repeat (22) tick();
    chk("popfull_q_empty", exp_q.size(), 32'd0);
    chk("popfull_busy", {31'd0, busy}, 32'd0);

    // Drop counter saturation
    tx_ready = 1'b0;
    for (int i = 0; i < 300; i++) push(32'h1111_0000 + i, (i < 5));
    chk("drop_sat", {24'd0, drop_count}, 32'd255);
    tx_ready = 1'b1;
    repeat (25) tick();
    chk("sat_q_empty", exp_q.size(), 32'd0);

    // Reset mid-frame after two beats
    push(32'hCAFE_0001, 1'b1);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("mrst_valid", {31'd0, tx_valid}, 32'd0);
    chk("mrst_data",  {24'd0, tx_data}, 32'd0);
    chk("mrst_last",  {31'd0, tx_last}, 32'd0);
    chk("mrst_busy",  {31'd0, busy}, 32'd0);
    chk("mrst_drop",  {24'd0, drop_count}, 32'd0);
    chk("mrst_remaining", exp_q.size(), 32'd2);
    exp_q.delete();
    tick(); tick();
    rst = 1'b0;
    tick();
    xs = xfer_cnt;
    push(32'h89AB_CDEF, 1'b1);
    repeat (8) tick();
    chk("post_rst_xfers", xfer_cnt - xs, 32'd4);
    chk("post_rst_q_empty", exp_q.size(), 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
